down_counter: RTL



---
 rtl/down_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable down-counter with a small IDLE/RUN/DONE state machine. A value is
// loaded, decremented once per cycle while `in` is high, and a one-cycle
// `done` pulse marks the count reaching zero. Decrement requests while no
// count is pending raise a sticky `underflow` flag. Immediate assertions
// state the safety properties so the block can also be used as a BMC target.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   load       load request, sampled at the rising edge of clk
//   load_val   value loaded when load=1 (WIDTH bits)
//   in         decrement enable
//   out        current count, registered (WIDTH bits)
//   busy       high while in RUN
//   done       one-cycle pulse while in DONE
//   underflow  sticky: decrement requested while the count is 0
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    // Encoding 2'b11 is unreachable; the next-state logic treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;

    // State, count and sticky flag registers; reset clears everything at once
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state logic. A load is accepted in every state and always wins over
    // a same-cycle decrement. A load of zero skips RUN and goes straight to
    // DONE so that RUN always holds a non-zero count. Outside RUN the count is
    // forced to zero, which also repairs the unused encoding.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        if (load) begin
            count_d     = load_val;
            underflow_d = 1'b0;
            state_d     = (load_val != '0) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (in) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    count_d = '0;
                    state_d = IDLE;
                    if (in) begin
                        underflow_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so no input reaches an output
    // combinationally.
    assign out       = count_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign underflow = underflow_q;

    // Safety properties, each inductive on its own: RUN holds exactly the
    // non-zero counts, and only the three named encodings ever appear.
    always @* begin
        if (!rst) begin
            assert (!(busy && done));
            assert ((state_q == RUN) || (count_q == '0));
            assert ((state_q != RUN) || (count_q != '0));
            assert ((state_q == IDLE) || (state_q == RUN) || (state_q == DONE));
        end
    end

endmodule
